tdc_therm_decoder: RTL and testbench
====================================

// Module: tdc_therm_decoder
// PURPOSE
//  Downstream consumer of the inverter-chain TDC capture register. Samples the
//  N_DELAY-bit thermometer code after a capture request, re-registers it into the
//  clk domain, and converts it to a binary tap count by popcount, which tolerates bubbles.
//  Accumulates 2**LOG_AVG samples and presents the sum and mean on a valid/ready port.
//  Flags overflow (all taps set) and bubbles (non-monotonic code) per batch.
// PARAMETERS
//  N_DELAY     32  thermometer width, equal to the TDC delay-chain tap count
//  LOG_AVG     2   log2 of samples per batch (0 = no averaging)
//  SETTLE_CYC  4   clk cycles waited after sample_req before capture (>=1)
// PORTS
//  clk         in   1              system clock
//  rst         in   1              synchronous, active-high reset
//  therm_in    in   N_DELAY        TDC thermometer code; bit0 = first tap
//  sample_req  in   1              1-cycle pulse: a new TDC capture has been taken
//  busy        out  1              high whenever FSM != IDLE
//  out_valid   out  1              batch result available
//  out_ready   in   1              consumer accepts result
//  out_sum     out  CW+LOG_AVG     sum of batch counts; CW = $clog2(N_DELAY+1)
//  out_mean    out  CW             out_sum >> LOG_AVG (truncated)
//  out_ovf     out  1              some sample in the batch was all-ones
//  out_bubble  out  1              some sample in the batch had a 0 below a 1
// BEHAVIOUR
//  - Decided interface facts: single clock clk. rst is synchronous and active-high.
//  - Reset: FSM=IDLE; all outputs 0; accumulator, sample counter and sticky flags 0.
//    rst overrides every other event in the same cycle. A batch cut by reset is discarded.
//  - FSM states and transitions:
//    IDLE   : sample_req=1 -> WAIT; load settle counter with SETTLE_CYC-1
//    WAIT   : counter decrements each cycle; at 0 -> CAP0
//    CAP0   : s1 <= therm_in -> CAP1
//    CAP1   : s2 <= s1 -> DEC   (two-stage capture; therm_in is quasi-static)
//    DEC    : cnt <= popcount(s2) (0..N_DELAY); ovf_s <= &s2;
//             bub_s <= (s2 != (1<<cnt)-1) -> ACC
//    ACC    : acc <= acc+cnt; ovf |= ovf_s; bub |= bub_s; nsmp <= nsmp+1;
//             if nsmp == 2**LOG_AVG-1 -> OUT, else -> IDLE
//    OUT    : out_valid=1; outputs driven from registered acc and flags;
//             out_valid && out_ready -> acc, nsmp, flags cleared; -> IDLE
//  - Latency: sample_req at edge k means therm_in is sampled at edge k+SETTLE_CYC+1.
//    For the last sample of a batch, out_valid rises at edge k+SETTLE_CYC+5.
//  - sample_req outside IDLE is ignored (not queued), including in the handshake cycle.
//  - In OUT, out_sum, out_mean, out_ovf and out_bubble stay stable until accepted.
//    out_valid falls in the cycle after the handshake.
//  - Widths: acc width is CW+LOG_AVG and cannot wrap; max = N_DELAY*2**LOG_AVG.
//  - All-zero code gives cnt=0 with no flag. All-ones gives cnt=N_DELAY with ovf=1.
//  - Outside OUT, out_sum, out_mean and the flags read 0.
// TESTING  (N_DELAY=32, LOG_AVG=2, SETTLE_CYC=4)
//  1. 4 reqs, therm=32'h0000_00FF -> out_sum=32, out_mean=8, ovf=0, bubble=0
//  2. therms with 3,5,7,9 ones -> out_sum=24, out_mean=6; valid at req4+9 cycles
//  3. One sample 32'hFFFF_FFFF, others 32'h0000_000F -> sum=44, mean=11, ovf=1
//  4. One sample 32'h0000_00F7, others 0 -> sum=7, mean=1, bubble=1, ovf=0
//  5. out_ready low 10 cycles in OUT, extra sample_req pulses -> outputs stable,
//     busy=1, reqs ignored; next batch after accept starts with acc=0
//  6. rst pulse during WAIT of the 3rd sample -> all outputs 0, FSM IDLE;
//     next 4 samples of 0x0F form a clean batch with sum=16

Source files
------------

// File: rtl/tdc_therm_decoder.sv
// Captures a quasi-static TDC thermometer code after a settle delay, converts it to a
// bubble-tolerant tap count by popcount, and averages 2**LOG_AVG samples per batch.
module tdc_therm_decoder #(
  parameter int N_DELAY    = 32,
  parameter int LOG_AVG    = 2,
  parameter int SETTLE_CYC = 4,
  localparam int CW = $clog2(N_DELAY+1),
  localparam int AW = CW + LOG_AVG
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_DELAY-1:0] therm_in_i,
  input  logic               sample_req_i,
  output logic               busy_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [AW-1:0]      out_sum_o,
  output logic [CW-1:0]      out_mean_o,
  output logic               out_ovf_o,
  output logic               out_bubble_o
);

  localparam int SW   = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int NW   = (LOG_AVG > 0) ? LOG_AVG : 1;
  localparam int NSMP = 2**LOG_AVG;

  typedef enum logic [2:0] {IDLE, WAIT, CAP0, CAP1, DEC, ACC, OUT} state_t;

  state_t             state_q, state_d;
  logic [SW-1:0]      settle_q, settle_d;
  logic [N_DELAY-1:0] s1_q, s1_d, s2_q, s2_d;
  logic [CW-1:0]      cnt_q, cnt_d, pop;
  logic               ovf_s_q, ovf_s_d, bub_s_q, bub_s_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [NW-1:0]      nsmp_q, nsmp_d;
  logic               ovf_q, ovf_d, bub_q, bub_d;
  logic               vld_q, vld_d;

  always_comb begin
    pop = '0;
    for (int i = 0; i < N_DELAY; i++) pop = pop + CW'(s2_q[i]);
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    cnt_d    = cnt_q;
    ovf_s_d  = ovf_s_q;
    bub_s_d  = bub_s_q;
    acc_d    = acc_q;
    nsmp_d   = nsmp_q;
    ovf_d    = ovf_q;
    bub_d    = bub_q;
    vld_d    = vld_q;
    case (state_q)
      IDLE: if (sample_req_i) begin
        state_d  = WAIT;
        settle_d = SW'(SETTLE_CYC-1);
      end
      WAIT: if (settle_q == '0) state_d = CAP0;
            else settle_d = settle_q - 1'b1;
      CAP0: begin s1_d = therm_in_i; state_d = CAP1; end
      CAP1: begin s2_d = s1_q;       state_d = DEC;  end
      DEC: begin
        cnt_d   = pop;
        ovf_s_d = &s2_q;
        // a clean code is exactly the low pop bits set; shifting by N_DELAY yields all-ones
        bub_s_d = s2_q != ~({N_DELAY{1'b1}} << pop);
        state_d = ACC;
      end
      ACC: begin
        acc_d   = acc_q + AW'(cnt_q);
        ovf_d   = ovf_q | ovf_s_q;
        bub_d   = bub_q | bub_s_q;
        nsmp_d  = nsmp_q + 1'b1;
        state_d = (nsmp_q == NW'(NSMP-1)) ? OUT : IDLE;
      end
      OUT: begin
        // valid is raised one cycle after entry so results come from settled registers
        if (!vld_q) vld_d = 1'b1;
        else if (out_ready_i) begin
          vld_d   = 1'b0;
          acc_d   = '0;
          nsmp_d  = '0;
          ovf_d   = 1'b0;
          bub_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      settle_q <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      cnt_q    <= '0;
      ovf_s_q  <= 1'b0;
      bub_s_q  <= 1'b0;
      acc_q    <= '0;
      nsmp_q   <= '0;
      ovf_q    <= 1'b0;
      bub_q    <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      cnt_q    <= cnt_d;
      ovf_s_q  <= ovf_s_d;
      bub_s_q  <= bub_s_d;
      acc_q    <= acc_d;
      nsmp_q   <= nsmp_d;
      ovf_q    <= ovf_d;
      bub_q    <= bub_d;
      vld_q    <= vld_d;
    end
  end

  assign busy_o       = state_q != IDLE;
  assign out_valid_o  = vld_q;
  assign out_sum_o    = vld_q ? acc_q : '0;
  assign out_mean_o   = vld_q ? CW'(acc_q >> LOG_AVG) : '0;
  assign out_ovf_o    = vld_q & ovf_q;
  assign out_bubble_o = vld_q & bub_q;

endmodule

// File: tb/tb_tdc_therm_decoder.sv
// Randomized and directed checks of tdc_therm_decoder against a count-the-ones batch model.
module tb_tdc_therm_decoder;
  localparam int N = 32, LA = 2, SC = 4, CW = 6, AW = 8;

  logic          clk = 1'b0;
  logic          rst, sample_req, out_ready;
  logic [N-1:0]  therm;
  logic          busy, out_valid, out_ovf, out_bubble;
  logic [AW-1:0] out_sum;
  logic [CW-1:0] out_mean;

  int vecs = 0, errs = 0;
  logic [31:0] bt [4];

  tdc_therm_decoder #(.N_DELAY(N), .LOG_AVG(LA), .SETTLE_CYC(SC)) dut (
    .clk_i(clk), .rst_i(rst), .therm_in_i(therm), .sample_req_i(sample_req),
    .busy_o(busy), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_sum_o(out_sum), .out_mean_o(out_mean), .out_ovf_o(out_ovf),
    .out_bubble_o(out_bubble));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  function automatic int ones(input logic [31:0] v);
    int c = 0;
    for (int i = 0; i < 32; i++) if (v[i]) c++;
    return c;
  endfunction

  function automatic bit has_bubble(input logic [31:0] v);
    bit seen0 = 0;
    for (int i = 0; i < 32; i++) begin
      if (!v[i]) seen0 = 1;
      else if (seen0) return 1;
    end
    return 0;
  endfunction

  // one capture: pulse req, then wait for idle (or for valid on the batch's last sample)
  task automatic sample(input logic [31:0] v, input bit last, input string tag);
    int n = 0;
    therm = v; sample_req = 1'b1; tick; sample_req = 1'b0;
    chk({tag, ".busy"}, busy, 1);
    if (last) begin
      while (!out_valid && n < 30) begin tick; n++; end
      chk({tag, ".vld_lat"}, n, SC + 5);
    end else begin
      while (busy && n < 30) begin tick; n++; end
      chk({tag, ".idle_lat"}, n, SC + 4);
    end
  endtask

  task automatic run_batch(input string tag, input int hold, input bit req_at_hs);
    int s = 0; bit ob = 0, oo = 0;
    logic [AW-1:0] sum0;
    for (int i = 0; i < 4; i++) begin
      s += ones(bt[i]);
      ob |= has_bubble(bt[i]);
      oo |= (bt[i] == 32'hFFFF_FFFF);
      sample(bt[i], i == 3, tag);
    end
    chk({tag, ".sum"},  out_sum, s);
    chk({tag, ".mean"}, out_mean, s / 4);
    chk({tag, ".ovf"},  out_ovf, oo);
    chk({tag, ".bub"},  out_bubble, ob);
    sum0 = AW'(s);
    for (int h = 0; h < hold; h++) begin
      sample_req = 1'($urandom_range(0, 1));
      tick;
      sample_req = 1'b0;
      chk({tag, ".hold_vld"}, out_valid, 1);
      chk({tag, ".hold_sum"}, out_sum, sum0);
      chk({tag, ".hold_busy"}, busy, 1);
    end
    out_ready = 1'b1; sample_req = req_at_hs; tick;
    out_ready = 1'b0; sample_req = 1'b0;
    chk({tag, ".post_vld"},  out_valid, 0);
    chk({tag, ".post_sum"},  out_sum, 0);
    chk({tag, ".post_busy"}, busy, 0);
  endtask

  function automatic logic [31:0] rnd_code();
    int n;
    case ($urandom_range(0, 3))
      0: begin
        n = $urandom_range(0, 32);
        return (n == 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
      end
      1: return $urandom;
      2: return 32'hFFFF_FFFF;
      default: return 32'h0;
    endcase
  endfunction

  initial begin
    rst = 1'b1; sample_req = 1'b0; out_ready = 1'b0; therm = '0;
    tick; tick;
    chk("rst.busy", busy, 0);
    chk("rst.vld",  out_valid, 0);
    chk("rst.sum",  out_sum, 0);
    chk("rst.mean", out_mean, 0);
    chk("rst.flags", {out_ovf, out_bubble}, 0);
    rst = 1'b0; tick;

    bt = '{32'hFF, 32'hFF, 32'hFF, 32'hFF};                       run_batch("t1", 0, 0);
    bt = '{32'h7, 32'h1F, 32'h7F, 32'h1FF};                      run_batch("t2", 1, 0);
    bt = '{32'hF, 32'hFFFF_FFFF, 32'hF, 32'hF};                  run_batch("t3", 2, 1);
    bt = '{32'h0, 32'h0, 32'hF7, 32'h0};                         run_batch("t4", 0, 1);
    bt = '{32'h3, 32'h3, 32'h3, 32'h3};                          run_batch("t5", 10, 1);
    bt = '{32'h1, 32'h1, 32'h1, 32'h1};                          run_batch("t5b", 0, 0);

    // reset while the third sample is still settling
    sample(32'hF, 0, "t6a");
    sample(32'hF, 0, "t6b");
    therm = 32'hF; sample_req = 1'b1; tick; sample_req = 1'b0; tick; tick;
    rst = 1'b1; tick; rst = 1'b0;
    chk("t6.busy", busy, 0);
    chk("t6.vld",  out_valid, 0);
    chk("t6.sum",  out_sum, 0);
    chk("t6.flags", {out_ovf, out_bubble}, 0);
    tick;
    bt = '{32'hF, 32'hF, 32'hF, 32'hF};                          run_batch("t6c", 0, 0);

    for (int b = 0; b < 20; b++) begin
      for (int i = 0; i < 4; i++) bt[i] = rnd_code();
      run_batch("rnd", $urandom_range(0, 5), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
